// File: rtl/alu_result_rx_pkg.sv
// Shared types, constants and CRC helper for the ALU result-stream receiver.
package alu_result_rx_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TYPE    = 3'd1,
        PAYLOAD = 3'd2,
        STOP    = 3'd3,
        GAP     = 3'd4
    } rx_state_t;

    localparam int         PKT_BITS  = 11;
    localparam logic [2:0] CRC3_POLY = 3'b011;

    // Fixed-width record fields; the result word is carried alongside because its width is a parameter.
    typedef struct packed {
        logic       kind;
        logic [3:0] flags;
        logic       crc_ok;
        logic [2:0] err_flags;
        logic       parity_ok;
        logic       frame_err;
    } alu_result_t;

    function automatic logic [2:0] crc3_step(input logic [2:0] crc, input logic din);
        logic fb;
        fb = crc[2] ^ din;
        return {crc[1:0], 1'b0} ^ (fb ? CRC3_POLY : 3'b000);
    endfunction

endpackage

// File: rtl/alu_rx_packet.sv
// Packet-level receiver: start/type/payload/stop sequencing and inter-packet gap timer.
module alu_rx_packet
    import alu_result_rx_pkg::*;
#(
    parameter int GAP_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sout,
    input  logic       frame_end,
    output logic       pkt_type,
    output logic [7:0] payload,
    output logic       bit_valid,
    output logic [2:0] bit_idx,
    output logic       pkt_done,
    output logic       gap_timeout
);

    localparam int PAYLOAD_BITS = PKT_BITS - 3;
    localparam int GW           = $clog2(GAP_MAX + 1);

    rx_state_t     state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          type_q, type_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;

    // Next-state logic; the frame sequencer decides at STOP whether another packet is expected.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        type_d      = type_q;
        gap_cnt_d   = gap_cnt_q;
        gap_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (!sout) state_d = TYPE;
                else       state_d = IDLE;
            end
            TYPE: begin
                type_d    = sout;
                bit_cnt_d = 3'd0;
                state_d   = PAYLOAD;
            end
            PAYLOAD: begin
                shift_d   = {shift_q[6:0], sout};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'(PAYLOAD_BITS - 1)) state_d = STOP;
                else                                   state_d = PAYLOAD;
            end
            STOP: begin
                gap_cnt_d = '0;
                state_d   = frame_end ? IDLE : GAP;
            end
            GAP: begin
                if (!sout) begin
                    state_d = TYPE;
                end else if (gap_cnt_q == GW'(GAP_MAX)) begin
                    gap_timeout = 1'b1;
                    state_d     = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            type_q    <= 1'b0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            type_q    <= type_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign pkt_type  = type_q;
    assign payload   = shift_q;
    assign bit_valid = (state_q == PAYLOAD);
    assign bit_idx   = bit_cnt_q;
    assign pkt_done  = (state_q == STOP);

endmodule

// File: rtl/alu_result_rx.sv
// ALU result-stream receiver top: frame sequencer, serial CRC-3 and one-deep output record.
module alu_result_rx
    import alu_result_rx_pkg::*;
#(
    parameter int NUM_BYTES = 4,
    parameter int GAP_MAX   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sout,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   res_kind,
    output logic [8*NUM_BYTES-1:0] res_data,
    output logic [3:0]             res_flags,
    output logic                   res_crc_ok,
    output logic [2:0]             res_err_flags,
    output logic                   res_parity_ok,
    output logic                   res_frame_err,
    output logic                   overflow
);

    localparam int DW = 8 * NUM_BYTES;
    localparam int CW = $clog2(NUM_BYTES + 1);

    logic          pkt_type, bit_valid, pkt_done, gap_timeout, frame_end;
    logic [7:0]    payload;
    logic [2:0]    bit_idx;

    logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic          kind_q, kind_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [2:0]    crc_q, crc_d;
    logic          res_valid_q, res_valid_d;
    logic          overflow_q, overflow_d;
    alu_result_t   res_q, res_d;
    logic [DW-1:0] res_data_q, res_data_d;

    logic          kind_cur, is_last, bad_type, rec_done;
    alu_result_t   rec;

    alu_rx_packet #(.GAP_MAX(GAP_MAX)) u_pkt (
        .clk         (clk),
        .rst_n       (rst_n),
        .sout        (sout),
        .frame_end   (frame_end),
        .pkt_type    (pkt_type),
        .payload     (payload),
        .bit_valid   (bit_valid),
        .bit_idx     (bit_idx),
        .pkt_done    (pkt_done),
        .gap_timeout (gap_timeout)
    );

    // Frame rules: the first type bit fixes the frame kind; the CTL packet closes a DATA frame.
    always_comb begin
        kind_cur  = (pkt_cnt_q == '0) ? pkt_type : kind_q;
        is_last   = (pkt_cnt_q == CW'(NUM_BYTES));
        if (pkt_cnt_q == '0) bad_type = 1'b0;
        else                 bad_type = (pkt_type != is_last);
        frame_end = pkt_done & (~sout | kind_cur | bad_type | is_last);
        rec_done  = frame_end | gap_timeout;

        rec           = '0;
        rec.kind      = kind_cur;
        rec.frame_err = gap_timeout | (pkt_done & (~sout | bad_type));
        if (pkt_done && sout && kind_cur) begin
            rec.err_flags = payload[6:4];
            rec.parity_ok = ~^payload;
            rec.frame_err = ~payload[7] | (payload[6:4] != payload[3:1]);
        end else if (pkt_done && sout && is_last && !bad_type) begin
            if (payload[7]) begin
                rec.frame_err = 1'b1;
            end else begin
                rec.flags  = payload[6:3];
                rec.crc_ok = (payload[2:0] == crc_q);
            end
        end else begin
            rec.crc_ok = 1'b0;
        end
    end

    // Sequencer state; the CRC covers data bits then the CTL marker and flag bits, never the received CRC.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        kind_d    = kind_q;
        acc_d     = acc_q;
        if (bit_valid && !kind_cur && (!is_last || bit_idx < 3'd5)) crc_d = crc3_step(crc_q, sout);
        else                                                          crc_d = crc_q;
        if (rec_done) begin
            pkt_cnt_d = '0;
            kind_d    = 1'b0;
            acc_d     = '0;
            crc_d     = 3'd0;
        end else if (pkt_done) begin
            pkt_cnt_d = pkt_cnt_q + CW'(1);
            kind_d    = kind_cur;
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (pkt_cnt_q == CW'(i)) acc_d[DW-8-8*i +: 8] = payload;
            end
        end else begin
            kind_d = kind_q;
        end
    end

    // One-deep output register; a record arriving while one is held unconsumed is dropped.
    always_comb begin
        res_valid_d = res_valid_q;
        res_d       = res_q;
        res_data_d  = res_data_q;
        overflow_d  = overflow_q;
        if (rec_done && (!res_valid_q || res_ready)) begin
            res_valid_d = 1'b1;
            res_d       = rec;
            res_data_d  = acc_q;
        end else if (rec_done) begin
            overflow_d = 1'b1;
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end else begin
            res_valid_d = res_valid_q;
        end
    end

    // Registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_cnt_q   <= '0;
            kind_q      <= 1'b0;
            acc_q       <= '0;
            crc_q       <= 3'd0;
            res_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            res_q       <= '0;
            res_data_q  <= '0;
        end else begin
            pkt_cnt_q   <= pkt_cnt_d;
            kind_q      <= kind_d;
            acc_q       <= acc_d;
            crc_q       <= crc_d;
            res_valid_q <= res_valid_d;
            overflow_q  <= overflow_d;
            res_q       <= res_d;
            res_data_q  <= res_data_d;
        end
    end

    assign res_valid     = res_valid_q;
    assign overflow      = overflow_q;
    assign res_kind      = res_q.kind;
    assign res_data      = res_data_q;
    assign res_flags     = res_q.flags;
    assign res_crc_ok    = res_q.crc_ok;
    assign res_err_flags = res_q.err_flags;
    assign res_parity_ok = res_q.parity_ok;
    assign res_frame_err = res_q.frame_err;

endmodule

// File: tb/tb_alu_result_rx.sv
// Testbench for alu_result_rx: directed vector table, handshake/reset sequences, random frames vs. a rule model.
module tb_alu_result_rx;

    localparam int NB = 4;
    localparam int GM = 8;

    logic          clk = 1'b0;
    logic          rst_n, sout, res_valid, res_ready, res_kind;
    logic [8*NB-1:0] res_data;
    logic [3:0]    res_flags;
    logic          res_crc_ok, res_parity_ok, res_frame_err, overflow;
    logic [2:0]    res_err_flags;

    alu_result_rx #(.NUM_BYTES(NB), .GAP_MAX(GM)) dut (
        .clk(clk), .rst_n(rst_n), .sout(sout), .res_valid(res_valid), .res_ready(res_ready),
        .res_kind(res_kind), .res_data(res_data), .res_flags(res_flags), .res_crc_ok(res_crc_ok),
        .res_err_flags(res_err_flags), .res_parity_ok(res_parity_ok), .res_frame_err(res_frame_err),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        kind;
        logic [31:0] data;
        logic [3:0]  flags;
        logic        crc_ok;
        logic [2:0]  err;
        logic        par;
        logic        ferr;
    } rec_t;

    typedef struct {
        logic        is_err;
        logic [31:0] data;
        logic [7:0]  ctl;
        int          bad_stop;
        int          bad_type;
        int          gap_pkt;
        int          gap_len;
    } frame_t;

    typedef struct {
        frame_t f;
        rec_t   exp;
    } vec_t;

    int errors = 0;
    int checks = 0;
    vec_t tbl[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic rec_t dut_rec();
        rec_t r;
        r.kind = res_kind; r.data = res_data; r.flags = res_flags; r.crc_ok = res_crc_ok;
        r.err = res_err_flags; r.par = res_parity_ok; r.ferr = res_frame_err;
        return r;
    endfunction

    function automatic frame_t mk(input logic e, input logic [31:0] d, input logic [7:0] c,
                                  input int bs, input int bt, input int gp, input int gl);
        frame_t f;
        f.is_err = e; f.data = d; f.ctl = c; f.bad_stop = bs; f.bad_type = bt; f.gap_pkt = gp; f.gap_len = gl;
        return f;
    endfunction

    function automatic rec_t mkr(input logic k, input logic [31:0] d, input logic [3:0] fl, input logic c,
                                 input logic [2:0] e, input logic p, input logic fe);
        rec_t r;
        r.kind = k; r.data = d; r.flags = fl; r.crc_ok = c; r.err = e; r.par = p; r.ferr = fe;
        return r;
    endfunction

    // CRC as the remainder of message * x^3 divided by x^3+x+1.
    function automatic logic [2:0] crc_model(input logic [31:0] d, input logic [3:0] fl);
        logic [39:0] v;
        v = {d, 1'b0, fl, 3'b000};
        for (int i = 39; i >= 3; i--) if (v[i]) v[i -: 4] = v[i -: 4] ^ 4'b1011;
        return v[2:0];
    endfunction

    function automatic rec_t model(input frame_t f);
        rec_t r;
        r = '0;
        r.kind = f.is_err;
        if (f.is_err) begin
            if (f.bad_stop == 0) begin
                r.ferr = 1'b1;
            end else begin
                r.err  = f.ctl[6:4];
                r.par  = (f.ctl[0] + f.ctl[1] + f.ctl[2] + f.ctl[3] + f.ctl[4] + f.ctl[5] + f.ctl[6] + f.ctl[7]) % 2 == 0;
                r.ferr = !f.ctl[7] || (f.ctl[6:4] != f.ctl[3:1]);
            end
            return r;
        end
        for (int k = 0; k <= NB; k++) begin
            if (k > 0 && f.gap_pkt == k && f.gap_len > GM) begin r.ferr = 1'b1; return r; end
            if (f.bad_type == k || f.bad_stop == k) begin r.ferr = 1'b1; return r; end
            if (k < NB) r.data[31-8*k -: 8] = f.data[31-8*k -: 8];
            else if (f.ctl[7]) r.ferr = 1'b1;
            else begin
                r.flags  = f.ctl[6:3];
                r.crc_ok = (f.ctl[2:0] == crc_model(f.data, f.ctl[6:3]));
            end
        end
        return r;
    endfunction

    task automatic drive_bit(input logic b);
        @(negedge clk);
        sout = b;
    endtask

    task automatic send_pkt(input logic t, input logic [7:0] p, input logic s);
        drive_bit(1'b0);
        drive_bit(t);
        for (int i = 7; i >= 0; i--) drive_bit(p[i]);
        drive_bit(s);
    endtask

    // Drives a frame up to the point where the receiver is expected to close it.
    task automatic send_frame(input frame_t f);
        int n;
        logic t;
        logic [7:0] p;
        n = f.is_err ? 1 : NB + 1;
        for (int k = 0; k < n; k++) begin
            if (k > 0 && f.gap_pkt == k) begin
                for (int g = 0; g < f.gap_len; g++) drive_bit(1'b1);
                if (f.gap_len > GM) return;
            end
            t = f.is_err ? 1'b1 : (k == NB);
            if (f.bad_type == k) t = ~t;
            p = (f.is_err || k == NB) ? f.ctl : f.data[31-8*k -: 8];
            send_pkt(t, p, (f.bad_stop == k) ? 1'b0 : 1'b1);
            if (f.bad_stop == k || f.bad_type == k) return;
        end
    endtask

    task automatic run_frame(input string name, input frame_t f, input rec_t exp);
        send_frame(f);
        check({name, " early"}, {63'd0, res_valid}, 64'd0);
        @(negedge clk);
        sout = 1'b1;
        check({name, " valid"}, {63'd0, res_valid}, 64'd1);
        check({name, " rec"}, {21'd0, dut_rec()}, {21'd0, exp});
        @(negedge clk);
        check({name, " drop"}, {63'd0, res_valid}, 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        frame_t f, fb;
        rec_t   ra;
        logic   seen;
        int     sel, n;
        logic [2:0] e;
        logic [3:0] fl;
        logic [2:0] c;
        logic [7:0] tmp;

        tbl[0]  = '{mk(0, 32'h0,        8'h00, -1, -1, -1, 0), mkr(0, 32'h0,        4'h0, 1, 3'b000, 0, 0)};
        tbl[1]  = '{mk(0, 32'h0,        8'h01, -1, -1, -1, 0), mkr(0, 32'h0,        4'h0, 0, 3'b000, 0, 0)};
        tbl[2]  = '{mk(1, 32'h0,        8'h93, -1, -1, -1, 0), mkr(1, 32'h0,        4'h0, 0, 3'b001, 1, 0)};
        tbl[3]  = '{mk(1, 32'h0,        8'h92, -1, -1, -1, 0), mkr(1, 32'h0,        4'h0, 0, 3'b001, 0, 0)};
        tbl[4]  = '{mk(0, 32'hAABBCCDD, 8'h00,  2, -1, -1, 0), mkr(0, 32'hAABB0000, 4'h0, 0, 3'b000, 0, 1)};
        tbl[5]  = '{mk(0, 32'h0,        8'h00, -1, -1, -1, 0), mkr(0, 32'h0,        4'h0, 1, 3'b000, 0, 0)};
        tbl[6]  = '{mk(0, 32'h11223344, 8'h00, -1, -1,  1, GM + 1), mkr(0, 32'h11000000, 4'h0, 0, 3'b000, 0, 1)};
        tbl[7]  = '{mk(0, 32'h0,        8'h00, -1, -1,  1, GM), mkr(0, 32'h0,        4'h0, 1, 3'b000, 0, 0)};
        tbl[8]  = '{mk(0, 32'h00000001, 8'h02, -1, -1, -1, 0), mkr(0, 32'h00000001, 4'h0, 1, 3'b000, 0, 0)};
        tbl[9]  = '{mk(0, 32'h0,        8'h0B, -1, -1, -1, 0), mkr(0, 32'h0,        4'h1, 1, 3'b000, 0, 0)};
        tbl[10] = '{mk(1, 32'h0,        8'h13, -1, -1, -1, 0), mkr(1, 32'h0,        4'h0, 0, 3'b001, 0, 1)};
        tbl[11] = '{mk(1, 32'h0,        8'h9D, -1, -1, -1, 0), mkr(1, 32'h0,        4'h0, 0, 3'b001, 0, 1)};
        tbl[12] = '{mk(0, 32'h55667788, 8'h00, -1,  1, -1, 0), mkr(0, 32'h55000000, 4'h0, 0, 3'b000, 0, 1)};
        tbl[13] = '{mk(0, 32'h0,        8'h80, -1, -1, -1, 0), mkr(0, 32'h0,        4'h0, 0, 3'b000, 0, 1)};
        tbl[14] = '{mk(0, 32'h0,        8'h00, -1,  4, -1, 0), mkr(0, 32'h0,        4'h0, 0, 3'b000, 0, 1)};

        rst_n = 1'b0; sout = 1'b1; res_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset valid", {63'd0, res_valid}, 64'd0);
        check("reset overflow", {63'd0, overflow}, 64'd0);
        check("reset fields", {21'd0, dut_rec()}, 64'd0);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 15; i++) run_frame($sformatf("vec%0d", i), tbl[i].f, tbl[i].exp);

        // Two frames with the consumer stalled: the first record is held, the second dropped.
        res_ready = 1'b0;
        f  = mk(0, 32'hDEADBEEF, {1'b0, 4'h5, crc_model(32'hDEADBEEF, 4'h5)}, -1, -1, -1, 0);
        fb = mk(0, 32'h01020304, 8'h00, -1, -1, -1, 0);
        ra = mkr(0, 32'hDEADBEEF, 4'h5, 1, 3'b000, 0, 0);
        send_frame(f);
        @(negedge clk); sout = 1'b1;
        check("ovf first valid", {63'd0, res_valid}, 64'd1);
        check("ovf first rec", {21'd0, dut_rec()}, {21'd0, ra});
        check("ovf not yet", {63'd0, overflow}, 64'd0);
        repeat (2) @(negedge clk);
        send_frame(fb);
        @(negedge clk); sout = 1'b1;
        check("ovf held rec", {21'd0, dut_rec()}, {21'd0, ra});
        check("ovf held valid", {63'd0, res_valid}, 64'd1);
        check("ovf sticky set", {63'd0, overflow}, 64'd1);
        res_ready = 1'b1;
        @(negedge clk);
        check("ovf after xfer valid", {63'd0, res_valid}, 64'd0);
        check("ovf stays", {63'd0, overflow}, 64'd1);
        repeat (2) @(negedge clk);

        // Reset in the middle of a DATA frame.
        send_pkt(1'b0, 8'h12, 1'b1);
        send_pkt(1'b0, 8'h34, 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        @(negedge clk); rst_n = 1'b0; sout = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        check("midrst valid", {63'd0, res_valid}, 64'd0);
        check("midrst overflow", {63'd0, overflow}, 64'd0);
        check("midrst fields", {21'd0, dut_rec()}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        check("midrst no record", {63'd0, seen}, 64'd0);
        run_frame("post reset", tbl[8].f, tbl[8].exp);

        // Random frames against the rule model.
        for (int r = 0; r < 60; r++) begin
            f = mk($urandom_range(0, 3) == 0, $urandom(), 8'h00, -1, -1, -1, 0);
            if (f.is_err) begin
                if ($urandom_range(0, 1) == 1) begin
                    f.ctl = 8'($urandom_range(0, 255));
                end else begin
                    e = 3'($urandom_range(0, 7));
                    tmp = {1'b1, e, e, 1'b0};
                    tmp[0] = ^tmp;
                    f.ctl = tmp;
                end
            end else begin
                fl = 4'($urandom_range(0, 15));
                c  = crc_model(f.data, fl);
                if ($urandom_range(0, 3) == 0) c = 3'($urandom_range(0, 7));
                f.ctl = {($urandom_range(0, 7) == 0), fl, c};
            end
            n = f.is_err ? 1 : NB + 1;
            sel = $urandom_range(0, 9);
            if (sel < 2) f.bad_stop = $urandom_range(0, n - 1);
            else if (sel == 2 && !f.is_err) f.bad_type = $urandom_range(1, NB);
            else if (sel == 3 && !f.is_err) begin f.gap_pkt = $urandom_range(1, NB); f.gap_len = GM + 1; end
            else if (sel < 7 && !f.is_err) begin f.gap_pkt = $urandom_range(1, NB); f.gap_len = $urandom_range(0, GM); end
            run_frame($sformatf("rand%0d", r), f, model(f));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_result_rx.md
# alu_result_rx

Synthesisable, parametrised receiver for the ALU serial result stream. Samples `sout` one bit per clock, reassembles DATA frames (NUM_BYTES data packets plus one CTL packet) and single-packet error CTL frames, checks CRC, parity and framing, and presents each decoded frame as one record on a valid/ready output. It sits between the ALU `sout` pin and scoreboard or host logic, and replaces the fixed 4-byte, check-free deserialiser.

## Interface
- NUM_BYTES, 4, data packets per DATA frame; result width is 8*NUM_BYTES.
- GAP_MAX, 8, maximum idle-high cycles allowed between packets of one frame.
- clk  in  1  clock; all sampling is on posedge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- sout  in  1  ALU serial output; idles high.
- res_valid  out  1  record available.
- res_ready  in  1  consumer accepts the record.
- res_kind  out  1  0 = DATA frame, 1 = error CTL frame.
- res_data  out  8*NUM_BYTES  result, first byte received is MSB.
- res_flags  out  4  DATA flags.
- res_crc_ok  out  1  received CRC equals the computed CRC.
- res_err_flags  out  3  {ERR_DATA, ERR_CRC, ERR_OP}.
- res_parity_ok  out  1  error byte has even parity.
- res_frame_err  out  1  framing, type or timeout violation.
- overflow  out  1  sticky; a record was dropped.

## Operation
- Packet format: 11 bits, MSB first. Start bit 0, type bit (0 = DATA, 1 = CTL), 8 payload bits, stop bit 1.
- Packet FSM: IDLE → TYPE → PAYLOAD (8 cycles, 3-bit counter) → STOP → GAP → TYPE / IDLE.
  - IDLE: `sout`=0 is the start bit.
  - GAP: waits for the next start bit. It counts idle cycles and times out when the count exceeds GAP_MAX.
- Frame rules:
  - First packet type=1: error frame. Payload is {1, err[2:0], err[2:0], p}.
    - `res_err_flags` = payload[6:4].
    - `res_parity_ok` = ~^payload.
    - `res_frame_err` is set if payload[7]=0 or payload[6:4]≠payload[3:1].
  - First packet type=0: DATA frame. Packets 0..NUM_BYTES-1 must be type 0. Packet NUM_BYTES must be type 1 with payload {0, flags[3:0], crc[2:0]}.
- CRC is CRC-3, polynomial x³+x+1, init 000. It is computed serially over the bit stream {data MSB-first, 1'b0, flags}. It is updated bit-wise during reception, not recomputed at the end.
- Any of the following sets `res_frame_err`=1: stop bit 0, wrong type bit, CTL payload[7]=1 in a DATA frame, or GAP timeout. The frame is aborted and the FSM returns to IDLE. A record is still emitted: `res_kind` comes from the first type bit, fields captured so far are kept, and the rest are 0.
- Output register is one deep. If a record completes while `res_valid`=1 and `res_ready`=0, the new record is dropped, `overflow` is set to 1, and the held record is unchanged.
- `overflow` is cleared only by reset.

## Timing
- Reset values: FSM=IDLE; `res_valid`=0; `overflow`=0; all `res_*` fields 0.
- Bit n of a packet is sampled n cycles after the start bit is sampled.
- `res_valid` rises on the cycle after the final stop bit is sampled (latency 1). The same applies after an abort.
- Handshake: a transfer occurs on a posedge with `res_valid`&&`res_ready`. `res_valid` drops on the next cycle unless a new record completes in that same cycle, in which case the new record is loaded and `res_valid` stays 1. Outputs are stable while `res_valid`&&!`res_ready`.
- Back-to-back packets need zero gap: the start bit may be sampled on the cycle after the stop bit.
- Reset asserted mid-frame discards the partial frame and emits no record.
- Minimum DATA frame duration: 11*(NUM_BYTES+1) cycles.

## Structure
- A shared package holds:
  - `rx_state_t` (IDLE, TYPE, PAYLOAD, STOP, GAP)
  - `PKT_BITS`=11
  - `CRC3_POLY`=3'b011
  - the `crc3_step(crc, bit)` function
  - the `alu_result_t` packed struct mirroring the output fields
- One sub-module, `alu_rx_packet`: the 11-bit packet shifter, start/stop/type checker and gap counter. The top holds the frame sequencer, CRC accumulator and output register.

## Test plan
- DATA frame, NUM_BYTES=4, bytes 00 00 00 00, CTL payload 0x00 → `res_kind`=0, `res_data`=0, `res_flags`=0, `res_crc_ok`=1, `res_valid` one cycle after the last stop bit.
- Same frame with CTL payload 0x01 (crc=001) → `res_crc_ok`=0, `res_frame_err`=0.
- Error frame, payload 0x93 → `res_kind`=1, `res_err_flags`=3'b001, `res_parity_ok`=1. Payload 0x92 → `res_parity_ok`=0.
- Stop bit of data packet 2 driven 0 → `res_frame_err`=1, FSM back to IDLE; the next valid frame decodes correctly.
- Gap of GAP_MAX+1 idle cycles after packet 1 → `res_frame_err`=1. Gap of exactly GAP_MAX → normal decode.
- `res_ready`=0 across two complete frames → first record held, `overflow`=1. `rst_n`=0 mid-frame → `res_valid`=0, `overflow`=0, no record emitted.
